// File: rtl/noise_pkg.sv
// Shared defaults and the per-channel configuration record for the noise bank.
package noise_pkg;
  localparam int LFSR_W_DEF   = 17;
  localparam int LFSR_TAP_DEF = 13;
  localparam int SEED_DEF     = 1;
  localparam int DIV_W_DEF    = 8;
  // Widest period the config record can carry; DIV_W must not exceed it.
  localparam int PERIOD_MAX_W = 16;

  typedef struct packed {
    logic [PERIOD_MAX_W-1:0] period;
  } chan_cfg_t;
endpackage

// File: rtl/noise_channel.sv
// One noise channel: period register, reload down-counter, sampled noise bit
// and resample tick.
module noise_channel
  import noise_pkg::*;
#(
  parameter int DIV_W          = DIV_W_DEF,
  parameter int DEFAULT_PERIOD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  logic             sound_en_i,
  input  logic             wr_en_i,
  input  logic [DIV_W-1:0] wr_period_i,
  input  logic             sample_i,
  output logic             noise_o,
  output logic             tick_o
);
  localparam logic [DIV_W-1:0] PER_RST = DIV_W'(DEFAULT_PERIOD);

  logic [DIV_W-1:0] per_q, per_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             noise_q, noise_d;
  logic             reload;

  assign reload = step_i && (cnt_q == '0);

  always_comb begin
    per_d   = per_q;
    cnt_d   = cnt_q;
    noise_d = noise_q;
    if (wr_en_i) per_d = wr_period_i;
    // Reload reads per_q, so a same-cycle write lands only on the next reload.
    if (!sound_en_i) begin
      cnt_d   = per_q;
      noise_d = 1'b0;
    end else if (reload) begin
      cnt_d   = per_q;
      noise_d = sample_i;
    end else if (step_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      per_q   <= PER_RST;
      cnt_q   <= PER_RST;
      noise_q <= 1'b0;
    end else begin
      per_q   <= per_d;
      cnt_q   <= cnt_d;
      noise_q <= noise_d;
    end
  end

  assign noise_o = noise_q;
  assign tick_o  = reload;
endmodule

// File: rtl/noise_bank.sv
// Shared Fibonacci LFSR driving NUM_CH independently clocked noise channels.
module noise_bank
  import noise_pkg::*;
#(
  parameter int LFSR_W         = LFSR_W_DEF,
  parameter int LFSR_TAP       = LFSR_TAP_DEF,
  parameter int SEED           = SEED_DEF,
  parameter int NUM_CH         = 2,
  parameter int DIV_W          = DIV_W_DEF,
  parameter int DEFAULT_PERIOD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              sound_enable,
  input  logic              cfg_wr,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_period,
  output logic [NUM_CH-1:0] noise_out,
  output logic [NUM_CH-1:0] noise_tick,
  output logic [LFSR_W-1:0] lfsr_state
);
  localparam logic [LFSR_W-1:0] SEED_V = LFSR_W'(SEED);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              step;
  logic              fb;
  chan_cfg_t         wr_cfg;

  assign step = clk_en && sound_enable && !rst;
  assign fb   = lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_TAP];

  // An all-zero register would stick forever, so it is reseeded even when idle.
  always_comb begin
    lfsr_d = lfsr_q;
    if (lfsr_q == '0)  lfsr_d = SEED_V;
    else if (step)     lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED_V;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_state    = lfsr_q;
  assign wr_cfg.period = PERIOD_MAX_W'(cfg_period);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic wr_en;
    // Out-of-range channel numbers match no instance and are dropped.
    assign wr_en = cfg_wr && !rst && (cfg_ch == 3'(c));

    noise_channel #(
      .DIV_W          (DIV_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .step_i      (step),
      .sound_en_i  (sound_enable),
      .wr_en_i     (wr_en),
      .wr_period_i (wr_cfg.period[DIV_W-1:0]),
      .sample_i    (lfsr_q[LFSR_W-1]),
      .noise_o     (noise_out[c]),
      .tick_o      (noise_tick[c])
    );
  end
endmodule

// File: tb/tb_noise_bank.sv
// Scoreboard bench for noise_bank with default parameters.
module tb_noise_bank;
  localparam int W = 17;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst, clk_en, sound_enable, cfg_wr;
  logic [2:0]   cfg_ch;
  logic [7:0]   cfg_period;
  logic [N-1:0] noise_out, noise_tick;
  logic [W-1:0] lfsr_state;

  noise_bank dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .sound_enable(sound_enable),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .noise_out(noise_out), .noise_tick(noise_tick), .lfsr_state(lfsr_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           known;
    int           lfsr;
    bit [N-1:0]   nout;
    bit [N-1:0]   tick;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference state of the block as the rules describe it.
  bit         m_known = 0;
  int         m_lfsr = 0;
  int         m_cnt[N];
  int         m_per[N];
  bit [N-1:0] m_nout = '0;

  function automatic void chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
  endfunction

  task automatic cyc(input bit r, input bit ce, input bit se, input bit wr,
                     input int ch, input int pv);
    exp_t e;
    bit   stp;
    int   msb;
    rst = r; clk_en = ce; sound_enable = se; cfg_wr = wr;
    cfg_ch = 3'(ch); cfg_period = 8'(pv);
    stp = !r && ce && se;
    e.known = m_known; e.lfsr = m_lfsr; e.nout = m_nout;
    for (int c = 0; c < N; c++) e.tick[c] = stp && (m_cnt[c] == 0);
    q.push_back(e);
    if (r) begin
      m_known = 1; m_lfsr = 1; m_nout = '0;
      for (int c = 0; c < N; c++) begin m_per[c] = 0; m_cnt[c] = 0; end
    end else begin
      msb = (m_lfsr >> (W-1)) & 1;
      for (int c = 0; c < N; c++) begin
        if (!se) begin m_nout[c] = 1'b0; m_cnt[c] = m_per[c]; end
        else if (stp) begin
          if (m_cnt[c] == 0) begin m_nout[c] = msb[0]; m_cnt[c] = m_per[c]; end
          else m_cnt[c] = m_cnt[c] - 1;
        end
      end
      if (wr && ch < N) m_per[ch] = pv & 8'hFF;
      if (m_lfsr == 0) m_lfsr = 1;
      else if (stp)
        m_lfsr = ((m_lfsr << 1) & ((1 << W) - 1)) | (((m_lfsr >> (W-1)) ^ (m_lfsr >> 13)) & 1);
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every cycle the DUT presents its outputs, compare with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("noise_tick", int'(noise_tick), int'(e.tick));
        if (e.known) begin
          chk("lfsr_state", int'(lfsr_state), e.lfsr);
          chk("noise_out", int'(noise_out), int'(e.nout));
        end
      end
    end
  end

  initial begin
    int guard;
    rst = 1; clk_en = 0; sound_enable = 0; cfg_wr = 0; cfg_ch = 0; cfg_period = 0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0);
    chk("reset_lfsr", int'(lfsr_state), 17'h00001);
    chk("reset_nout", int'(noise_out), 0);
    chk("reset_tick", int'(noise_tick), 0);

    // LFSR walks a single one up to bit 13, then the tap feeds back.
    for (int k = 1; k <= 14; k++) begin
      cyc(0, 1, 1, 0, 0, 0);
      chk("lfsr_seq", int'(lfsr_state), (k <= 13) ? (1 << k) : 17'h04001);
    end

    // Configure per0=0, per1=3 with sound off so counters preload.
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 1, 1, 3);
    cyc(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) cyc(0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++)  cyc(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++)  cyc(0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++)  cyc(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++)  cyc(0, 1, 1, 0, 0, 0);

    // Out-of-range channel, and a write hidden under reset.
    cyc(0, 1, 1, 1, 5, 9);
    for (int k = 0; k < 6; k++) cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 1, 7);
    for (int k = 0; k < 4; k++) cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 3);
    cyc(0, 0, 0, 0, 0, 0);

    // Period change on the exact cycle channel 1 reloads.
    guard = 0;
    while (m_cnt[1] != 0 && guard < 20) begin cyc(0, 1, 1, 0, 0, 0); guard++; end
    chk("reload_found", int'(m_cnt[1] == 0), 1);
    cyc(0, 1, 1, 1, 1, 1);
    for (int k = 0; k < 10; k++) cyc(0, 1, 1, 0, 0, 0);

    // Randomized traffic.
    for (int k = 0; k < 600; k++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 7), $urandom_range(0, 5));

    cyc(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
